micro_sequencer: RTL and testbench

//  Parametrised T-state sequencer and microcode addresser for the bus computer.

---
 rtl/micro_sequencer.sv | 120 ++++++++++++
 tb/tb_micro_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// micro_sequencer: T-state tick generator and microcode addresser {flags, opcode, step}.
// Define STEP_DEBOUNCE_EN to insert a DEB_CYCLES stability filter on the step button.
module micro_sequencer #(
  parameter int OPCODE_W   = 4,
  parameter int FLAG_W     = 2,
  parameter int STEP_W     = 3,
  parameter int NUM_STEPS  = 5,
  parameter int PRESCALE   = 65536,
  parameter int DEB_CYCLES = 1024
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               run_en_i,
  input  logic                               step_btn_i,
  input  logic [OPCODE_W-1:0]                opcode_i,
  input  logic [FLAG_W-1:0]                  flags_i,
  input  logic                               halt_req_i,
  input  logic                               step_rst_i,
  output logic                               tick_o,
  output logic [STEP_W-1:0]                  step_o,
  output logic [FLAG_W+OPCODE_W+STEP_W-1:0]  uaddr_o,
  output logic                               halted_o
);
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PRE_ARM = PW'(PRESCALE - 2);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_STEPS - 1);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_STEP, S_HALT} state_e;

  state_e            state_q;
  logic [PW-1:0]     pre_q;
  logic [STEP_W-1:0] step_q, step_d;
  logic              tick_q, btn_s1_q, btn_s2_q, btn_d_q, run_s1_q, run_s2_q;
  logic              btn_lvl, stepreq;

`ifdef STEP_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);
  logic [DW-1:0] deb_cnt_q;
  logic          deb_lvl_q;
  // The filtered level flips only after DEB_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt_q <= '0;
      deb_lvl_q <= 1'b0;
    end else if (btn_s2_q == deb_lvl_q) begin
      deb_cnt_q <= '0;
    end else if (deb_cnt_q == DW'(DEB_CYCLES - 1)) begin
      deb_cnt_q <= '0;
      deb_lvl_q <= btn_s2_q;
    end else begin
      deb_cnt_q <= deb_cnt_q + 1'b1;
    end
  end
  assign btn_lvl = deb_lvl_q;
`else
  assign btn_lvl = btn_s2_q & (DEB_CYCLES >= 0);
`endif

  assign stepreq = btn_lvl & ~btn_d_q;

  always_comb begin
    step_d = step_q;
    if (tick_q && !halt_req_i)
      step_d = (step_rst_i || step_q == STEP_LAST) ? '0 : step_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_INIT;
      pre_q    <= '0;
      step_q   <= '0;
      tick_q   <= 1'b0;
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
      btn_d_q  <= 1'b0;
      run_s1_q <= 1'b0;
      run_s2_q <= 1'b0;
    end else begin
      btn_s1_q <= step_btn_i;
      btn_s2_q <= btn_s1_q;
      btn_d_q  <= btn_lvl;
      run_s1_q <= run_en_i;
      run_s2_q <= run_s1_q;
      step_q   <= step_d;
      // First cycle after reset: pick the mode and preload the run_en synchroniser to match.
      if (state_q == S_INIT) begin
        state_q  <= run_en_i ? S_RUN : S_STEP;
        run_s2_q <= run_en_i;
      end else if (tick_q && halt_req_i) begin
        state_q <= S_HALT;
        tick_q  <= 1'b0;
      end else if (state_q == S_RUN) begin
        if (!run_s2_q) begin
          state_q <= S_STEP;
          pre_q   <= '0;
          tick_q  <= 1'b0;
        end else begin
          pre_q  <= (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
          tick_q <= (pre_q == PRE_ARM);
        end
      end else if (state_q == S_STEP) begin
        if (run_s2_q) begin
          state_q <= S_RUN;
          pre_q   <= '0;
          tick_q  <= 1'b0;
        end else begin
          tick_q <= stepreq & ~tick_q;
        end
      end else begin
        tick_q <= 1'b0;
      end
    end
  end

  assign tick_o   = tick_q;
  assign step_o   = step_q;
  assign halted_o = (state_q == S_HALT);
  assign uaddr_o  = {flags_i, opcode_i, step_q};
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed checks of run/step ticking, step counter, halt and async reset.
module tb_micro_sequencer;
  logic       clk = 1'b0;
  logic       rst_n, run_en, step_btn, halt_req, step_rst;
  logic [3:0] opcode;
  logic [1:0] flags;
  logic       tick, halted;
  logic [2:0] step;
  logic [8:0] uaddr;
  int checks = 0;
  int errors = 0;
  int n, c;

  micro_sequencer #(.OPCODE_W(4), .FLAG_W(2), .STEP_W(3), .NUM_STEPS(5), .PRESCALE(4), .DEB_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .run_en_i(run_en), .step_btn_i(step_btn), .opcode_i(opcode),
    .flags_i(flags), .halt_req_i(halt_req), .step_rst_i(step_rst), .tick_o(tick),
    .step_o(step), .uaddr_o(uaddr), .halted_o(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!tick && cyc <= 50);
  endtask

  task automatic count_ticks(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tick) cnt++;
    end
  endtask

  task automatic do_reset(input logic mode);
    rst_n = 1'b0;
    run_en = mode;
    step_btn = 1'b0;
    halt_req = 1'b0;
    step_rst = 1'b0;
    #1;
    chk("reset_tick", tick, 0);
    chk("reset_step", step, 0);
    chk("reset_halted", halted, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    opcode = 4'hA;
    flags = 2'b10;
    // T1: free run, tick every 4 clk, step 0..4 then wrap
    do_reset(1'b1);
    for (int s = 0; s < 6; s++) begin
      wait_tick(n);
      chk("t1_interval", n, 4);
      chk("t1_step", step, s % 5);
      chk("t1_uaddr", uaddr, {2'b10, 4'hA, 3'(s % 5)});
    end
    @(negedge clk);
    chk("t1_tick_width", tick, 0);
    wait_tick(n);
    chk("t1_step_b", step, 1);
    // T2: early end of instruction at step 2
    wait_tick(n);
    chk("t2_step2", step, 2);
    step_rst = 1'b1;
    wait_tick(n);
    chk("t2_early_wrap", step, 0);
    step_rst = 1'b0;
    wait_tick(n);
    chk("t2_step1", step, 1);
    wait_tick(n);
    wait_tick(n);
    chk("t3_step3", step, 3);
    // T3: halt wins over step_rst
    halt_req = 1'b1;
    step_rst = 1'b1;
    @(negedge clk);
    chk("t3_halted", halted, 1);
    chk("t3_tick", tick, 0);
    chk("t3_step_hold", step, 3);
    halt_req = 1'b0;
    step_rst = 1'b0;
    count_ticks(100, c);
    chk("t3_no_ticks", c, 0);
    chk("t3_still_halted", halted, 1);
    chk("t3_step_still", step, 3);
    // T5: async reset away from any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("t5_step", step, 0);
    chk("t5_tick", tick, 0);
    chk("t5_halted", halted, 0);
    // T4: single-step mode
    do_reset(1'b0);
    count_ticks(10, c);
    chk("t4_idle", c, 0);
    step_btn = 1'b1;
    wait_tick(n);
    chk("t4_latency", n, 3);
    chk("t4_first_step", step, 0);
    step_btn = 1'b0;
    c = 0;
    for (int p = 0; p < 2; p++) begin
      count_ticks(5, n);
      c += n;
      step_btn = 1'b1;
      count_ticks(3, n);
      c += n;
      step_btn = 1'b0;
    end
    count_ticks(6, n);
    c += n;
    step_btn = 1'b1;
    count_ticks(20, n);
    c += n;
    step_btn = 1'b0;
    count_ticks(10, n);
    c += n;
    chk("t4_more_ticks", c, 3);
    chk("t4_step", step, 4);
    // Mode change back to free run
    run_en = 1'b1;
    wait_tick(n);
    chk("mc_found_tick", tick, 1);
    chk("mc_step", step, 4);
    wait_tick(n);
    chk("mc_interval", n, 4);
    chk("mc_wrap", step, 0);
`ifdef STEP_DEBOUNCE_EN
    // T6: debounce rejects a 5-clk glitch and accepts a 12-clk press
    do_reset(1'b0);
    step_btn = 1'b1;
    count_ticks(5, c);
    step_btn = 1'b0;
    count_ticks(25, n);
    chk("t6_glitch", c + n, 0);
    step_btn = 1'b1;
    count_ticks(12, c);
    step_btn = 1'b0;
    count_ticks(25, n);
    chk("t6_press", c + n, 1);
    chk("t6_step", step, 1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
